calculate_n: RTL and testbench
==============================

// Module: calculate_n
// PURPOSE
//   Parametrised, key-locked arithmetic unit with an HLS-style ap_ctrl_hs handshake.
//   Successor to the fixed 32-bit single-function calculate core: adds a WIDTH parameter,
//   an op select (add/sub/xor/multi-cycle multiply) and a deterministic key-mismatch corruption mask.
//   Sits behind the same top-level wrapper style; the wrapper ties working_key to the golden key.
// PARAMETERS
//   WIDTH      32                 operand/result width in bits (>=2)
//   KEY_WIDTH  255                working_key width in bits
//   GOLDEN_KEY {KEY_WIDTH{1'b0}}  unlock key; result is exact only when working_key==GOLDEN_KEY
// PORTS
//   ap_clk       in   1          clock, all state on rising edge
//   ap_rst       in   1          asynchronous, active-high reset
//   ap_start     in   1          request; sampled only in IDLE
//   ap_done      out  1          one-cycle pulse, ap_return valid that cycle
//   ap_idle      out  1          1 when in IDLE
//   ap_ready     out  1          1 when inputs are being consumed this cycle
//   op           in   2          0=add 1=sub(a-b) 2=mul(low WIDTH bits) 3=xor
//   a            in   WIDTH      operand A
//   b            in   WIDTH      operand B
//   working_key  in   KEY_WIDTH  lock key, sampled with operands
//   ap_return    out  WIDTH      result; holds last value until next ap_done
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, ap_done=0, ap_return=0, internal regs=0; ap_idle=1 after.
//   FSM states: IDLE, EXEC, MUL, DONE.
//   IDLE: ap_idle=1; ap_ready = ap_start (combinational). On edge with ap_start=1: latch a,b,op,
//     working_key; go EXEC if op!=2, else MUL with counter=0, acc=0.
//   EXEC: one cycle; compute a+b / a-b / a^b modulo 2^WIDTH -> DONE.
//   MUL: shift-add, one multiplier bit per cycle, LSB first; exactly WIDTH cycles, then DONE.
//   DONE: ap_done=1 for exactly this cycle, ap_return updated on entry; next state IDLE.
//     ap_start during EXEC/MUL/DONE is ignored (ap_ready=0, ap_idle=0); no queuing.
//   Latency (start accepted in cycle T): add/sub/xor -> ap_done in T+2; mul -> ap_done in T+WIDTH+2.
//   Lock: diff = working_key ^ GOLDEN_KEY, zero-padded to a multiple of WIDTH, split into WIDTH-bit
//     chunks; mask = XOR of all chunks; ap_return = raw_result ^ mask. Key match -> mask=0.
//   Arithmetic: all results truncated to WIDTH bits; no overflow/carry flag; sub wraps.
//   Operands change after acceptance: no effect (latched copies used).
//   Reset mid-EXEC/MUL/DONE: operation abandoned, no ap_done pulse, ap_return=0.
// TESTING (WIDTH=32, KEY_WIDTH=255, working_key=GOLDEN_KEY unless stated)
//   add a=5 b=7 start in T -> ap_ready=1 in T, ap_done=1 only in T+2, ap_return=12, ap_idle=1 in T+3.
//   sub a=3 b=5 -> ap_return=32'hFFFF_FFFE; xor a=32'hF0F0_F0F0 b=32'hFFFF_0000 -> 32'h0F0F_F0F0.
//   mul a=1234 b=5678 -> ap_done in T+34, ap_return=7006652; a=b=32'h0001_0000 -> 0 (truncation).
//   add 5+7 with working_key bit 0 flipped -> 13; bit 40 flipped -> 12^32'h100=268.
//   ap_start held high through a mul -> exactly one ap_done; next accept in the IDLE cycle after DONE.
//   assert ap_rst in MUL cycle T+10 -> ap_done never pulses, ap_return=0, ap_idle=1 after release.

Source files
------------

// File: rtl/calculate_n.sv
// calculate_n: key-locked arithmetic unit (add/sub/xor single-cycle, shift-add
// multiply) behind an ap_ctrl_hs style start/done/idle/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for ap_start; operands/op/key latched on accept
// EXEC   | produce raw result, apply key mask, load ap_return
// MUL    | shift-add multiply, one multiplier bit per cycle, LSB first
// DONE   | ap_done pulse, ap_return valid; returns to IDLE
module calculate_n #(
   parameter int                   WIDTH      = 32,
   parameter int                   KEY_WIDTH  = 255,
   parameter logic [KEY_WIDTH-1:0] GOLDEN_KEY = '0
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic                 ap_start,
   output logic                 ap_done,
   output logic                 ap_idle,
   output logic                 ap_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [KEY_WIDTH-1:0] working_key,
   output logic [WIDTH-1:0]     ap_return
);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_XOR = 2'd3;

   // key difference is padded up to a whole number of WIDTH-bit chunks
   localparam int N_CHUNK = (KEY_WIDTH + WIDTH - 1) / WIDTH;
   localparam int PAD_W   = N_CHUNK * WIDTH;

   localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     ret_q, ret_d;

   logic [PAD_W-1:0]     diff_pad;
   logic [WIDTH-1:0]     mask;
   logic [WIDTH-1:0]     raw;

   // corruption mask: XOR-fold of the key difference into WIDTH bits
   always_comb begin
      diff_pad = PAD_W'(key_q ^ GOLDEN_KEY);
      mask     = '0;
      for (int i = 0; i < N_CHUNK; i++) begin
         mask = mask ^ diff_pad[i*WIDTH +: WIDTH];
      end
   end

   // unmasked result; multiply result has already accumulated in acc_q
   always_comb begin
      raw = acc_q;
      case (op_q)
         OP_ADD:  raw = a_q + b_q;
         OP_SUB:  raw = a_q - b_q;
         OP_XOR:  raw = a_q ^ b_q;
         default: raw = acc_q;
      endcase
   end

   // next-state, datapath updates and handshake outputs
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      key_d    = key_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ret_d    = ret_q;
      ap_idle  = 1'b0;
      ap_ready = 1'b0;
      ap_done  = 1'b0;

      case (state_q)
         S_IDLE: begin
            ap_idle  = 1'b1;
            ap_ready = ap_start;
            if (ap_start) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               key_d   = working_key;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_MUL: begin
            if (b_q[0]) begin
               acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            ret_d   = raw ^ mask;
            state_d = S_DONE;
         end
         S_DONE: begin
            ap_done = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         key_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         key_q   <= key_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
      end
   end

   assign ap_return = ret_q;

endmodule

// File: tb/tb_calculate_n.sv
// Bench for calculate_n: vector table driven through the handshake, expected
// results queued on accept and popped on ap_done, plus hand sequences for
// start held high through a multiply and reset in the middle of a multiply.
module tb_calculate_n;

   localparam int               W   = 32;
   localparam int               KW  = 255;
   localparam logic [KW-1:0]    GK  = 255'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_A5A5_5A5A_C3C3_3C3C_DEAD_BEEF_CAFE_F00D;
   localparam int               NV  = 16;

   logic          ap_clk = 1'b0;
   logic          ap_rst = 1'b1;
   logic          ap_start = 1'b0;
   logic          ap_done, ap_idle, ap_ready;
   logic [1:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [KW-1:0] working_key = GK;
   logic [W-1:0]  ap_return;

   calculate_n #(.WIDTH(W), .KEY_WIDTH(KW), .GOLDEN_KEY(GK)) dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .ap_start    (ap_start),
      .ap_done     (ap_done),
      .ap_idle     (ap_idle),
      .ap_ready    (ap_ready),
      .op          (op),
      .a           (a),
      .b           (b),
      .working_key (working_key),
      .ap_return   (ap_return)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           flip;   // key bit to flip, -1 for golden key
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t         tv [NV];
   logic [W-1:0] exp_q [$];
   int           n_pass = 0;
   int           n_tot  = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      case (o)
         2'd0:    r = x + y;
         2'd1:    r = x - y;
         2'd2:    r = x * y;
         default: r = x ^ y;
      endcase
      return r;
   endfunction

   function automatic logic [KW-1:0] key_of(input int flip);
      logic [KW-1:0] k;
      k = GK;
      if (flip >= 0) k[flip] = ~k[flip];
      return k;
   endfunction

   // one transaction: drive in cycle T, expect ap_done at T+lat
   task automatic run_vec(input vec_t v, input string tag);
      int           n;
      logic [W-1:0] e;
      @(negedge ap_clk);
      op          = v.op;
      a           = v.a;
      b           = v.b;
      working_key = key_of(v.flip);
      ap_start    = 1'b1;
      #1;
      chk({tag, " ready"}, W'(ap_ready), W'(1));
      exp_q.push_back(v.exp);
      @(negedge ap_clk);
      ap_start    = 1'b0;
      a           = $urandom;
      b           = $urandom;
      working_key = ~GK;
      n = 1;
      while (!ap_done && n < 100) begin
         @(negedge ap_clk);
         n++;
      end
      chk({tag, " latency"}, W'(n), W'(v.lat));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk({tag, " return"}, ap_return, e);
      @(negedge ap_clk);
      chk({tag, " idle_after"}, {ap_idle, ap_done, ap_return[W-3:0]}, {1'b1, 1'b0, e[W-3:0]});
   endtask

   initial begin
      int           n, dones, first_done;
      logic [W-1:0] e;

      tv[0]  = '{2'd0, 32'd5,         32'd7,         -1,  32'd12,        2};
      tv[1]  = '{2'd1, 32'd3,         32'd5,         -1,  32'hFFFF_FFFE, 2};
      tv[2]  = '{2'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, -1,  32'h0F0F_F0F0, 2};
      tv[3]  = '{2'd2, 32'd1234,      32'd5678,      -1,  32'd7006652,   34};
      tv[4]  = '{2'd2, 32'h0001_0000, 32'h0001_0000, -1,  32'd0,         34};
      tv[5]  = '{2'd0, 32'd5,         32'd7,         0,   32'd13,        2};
      tv[6]  = '{2'd0, 32'd5,         32'd7,         40,  32'd268,       2};
      tv[7]  = '{2'd0, 32'd5,         32'd7,         254, 32'h4000_000C, 2};
      tv[8]  = '{2'd0, 32'hFFFF_FFFF, 32'd1,         -1,  32'd0,         2};
      tv[9]  = '{2'd1, 32'd0,         32'd1,         -1,  32'hFFFF_FFFF, 2};
      tv[10] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1,  32'd1,         34};
      tv[11] = '{2'd2, 32'd6,         32'd7,         0,   32'd43,        34};
      for (int i = 12; i < NV; i++) begin
         tv[i].op   = 2'($urandom_range(0, 3));
         tv[i].a    = $urandom;
         tv[i].b    = $urandom;
         tv[i].flip = -1;
         tv[i].exp  = model(tv[i].op, tv[i].a, tv[i].b);
         tv[i].lat  = (tv[i].op == 2'd2) ? 34 : 2;
      end

      // reset state
      repeat (3) @(negedge ap_clk);
      chk("reset idle", W'(ap_idle), W'(1));
      chk("reset done", W'(ap_done), W'(0));
      chk("reset return", ap_return, '0);
      chk("reset ready", W'(ap_ready), W'(0));
      ap_rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_vec(tv[i], $sformatf("vec%0d", i));
      end

      // start held high through a multiply, then an add accepted right after DONE
      @(negedge ap_clk);
      op = 2'd2; a = 32'd1234; b = 32'd5678; working_key = GK; ap_start = 1'b1;
      exp_q.push_back(32'd7006652);
      n = 0; dones = 0; first_done = -1;
      while (n < 40) begin
         @(negedge ap_clk);
         n++;
         if (n > 1 && n < 34) begin
            if (ap_ready) chk("hold ready_busy", W'(ap_ready), W'(0));
            a = $urandom;
         end
         if (n == 34) begin
            op = 2'd0; a = 32'd5; b = 32'd7;
         end
         if (n == 35) begin
            #1;
            chk("hold ready_after_done", W'(ap_ready), W'(1));
            exp_q.push_back(32'd12);
         end
         if (n == 36) ap_start = 1'b0;
         if (ap_done) begin
            dones++;
            if (first_done < 0) first_done = n;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("hold return", ap_return, e);
         end
      end
      chk("hold first_done", W'(first_done), W'(34));
      chk("hold done_count", W'(dones), W'(2));
      chk("hold queue_empty", W'(exp_q.size()), W'(0));

      // reset asserted in MUL cycle T+10
      run_vec(tv[0], "pre_rst");
      @(negedge ap_clk);
      op = 2'd2; a = 32'd1234; b = 32'd5678; ap_start = 1'b1;
      dones = 0;
      @(negedge ap_clk);
      ap_start = 1'b0;
      for (int k = 2; k <= 10; k++) begin
         @(negedge ap_clk);
         if (ap_done) dones++;
      end
      ap_rst = 1'b1;
      #1;
      chk("rst return_async", ap_return, '0);
      chk("rst idle_async", W'(ap_idle), W'(1));
      @(negedge ap_clk);
      ap_rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge ap_clk);
         if (ap_done) dones++;
      end
      chk("rst no_done", W'(dones), W'(0));
      chk("rst return", ap_return, '0);
      chk("rst idle", W'(ap_idle), W'(1));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
